// File: rtl/tgate_mux4_if.sv
`default_nettype none
// ============================================================================
// Module      : tgate_mux4_if
// Description : Bundle of data, select, sweep-control and result signals
//               for the tgate_mux4 selection primitive.
//               master : drives x0..x3, c0, c1, bist_en; observes results
//               slave  : receives inputs; drives out_comb, out_q,
//                        bist_done, bist_err
// Revision    : 1.0 - initial release
// ============================================================================
interface tgate_mux4_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] x0;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] x2;
    logic [WIDTH-1:0] x3;
    logic             c0;
    logic             c1;
    logic             bist_en;
    logic [WIDTH-1:0] out_comb;
    logic [WIDTH-1:0] out_q;
    logic             bist_done;
    logic             bist_err;

    modport master (
        output x0, x1, x2, x3, c0, c1, bist_en,
        input  out_comb, out_q, bist_done, bist_err
    );

    modport slave (
        input  x0, x1, x2, x3, c0, c1, bist_en,
        output out_comb, out_q, bist_done, bist_err
    );
endinterface
`default_nettype wire

// File: rtl/tgate_mux4.sv
`default_nettype none
// ============================================================================
// Module      : tgate_mux4
// Description : 4:1 multiplexer built as a two-level transmission-gate tree
//               (stage 1 under c0, stage 2 under c1) with a registered copy
//               of the result and a built-in 64-pattern sweep self-check.
// Ports       : clk     - rising-edge clock
//               rst_n   - asynchronous active-low reset
//               bus     - tgate_mux4_if.slave:
//                         x0..x3   data inputs, selected by {c1,c0}
//                         c0, c1   first / second level selects
//                         bist_en  1 = internal sweep drives the mux
//                         out_comb combinational result
//                         out_q    out_comb registered on clk
//                         bist_done pulse in the cycle cnt goes 63 -> 0
//                         bist_err sticky sweep mismatch flag
// Revision    : 1.0 - initial release
// ============================================================================
module tgate_mux4 #(
    parameter int WIDTH = 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    tgate_mux4_if.slave      bus
);

    // Sweep counter: bits [3:0] are the four data patterns, [5:4] the select.
    logic [5:0]       cnt_q;
    logic [5:0]       cnt_d;
    logic [WIDTH-1:0] out_q;
    logic             exp_q;
    logic             en_q;
    logic             err_q;
    logic             err_d;

    // Effective mux inputs after the port / sweep source choice.
    logic [WIDTH-1:0] w_x0;
    logic [WIDTH-1:0] w_x1;
    logic [WIDTH-1:0] w_x2;
    logic [WIDTH-1:0] w_x3;
    logic             w_c0;
    logic             w_c1;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_out;
    logic             w_exp;

    assign w_x0 = bus.bist_en ? {WIDTH{cnt_q[0]}} : bus.x0;
    assign w_x1 = bus.bist_en ? {WIDTH{cnt_q[1]}} : bus.x1;
    assign w_x2 = bus.bist_en ? {WIDTH{cnt_q[2]}} : bus.x2;
    assign w_x3 = bus.bist_en ? {WIDTH{cnt_q[3]}} : bus.x3;
    assign w_c0 = bus.bist_en ? cnt_q[4] : bus.c0;
    assign w_c1 = bus.bist_en ? cnt_q[5] : bus.c1;

    // Two-level tree, one per bit, mirroring the pass-gate pairs.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign w_a[i]   = w_c0 ? w_x1[i] : w_x0[i];
        assign w_b[i]   = w_c0 ? w_x3[i] : w_x2[i];
        assign w_out[i] = w_c1 ? w_b[i]  : w_a[i];
    end

    // Reference bit for the sweep, computed directly from the counter so it
    // is independent of the tree above.
    assign w_exp = cnt_q[cnt_q[5:4]];

    assign cnt_d = bus.bist_en ? cnt_q + 6'd1 : cnt_q;

    // Compare only once out_q was itself captured under sweep control
    // (bist_en high on the previous edge as well).
    assign err_d = err_q | (bus.bist_en & en_q & (out_q[0] != exp_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            cnt_q <= 6'd0;
            exp_q <= 1'b0;
            en_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            out_q <= w_out;
            cnt_q <= cnt_d;
            exp_q <= w_exp;
            en_q  <= bus.bist_en;
            err_q <= err_d;
        end
    end

    assign bus.out_comb  = w_out;
    assign bus.out_q     = out_q;
    // High for the cycle whose closing edge wraps the counter; cnt resets to
    // 0 so this is also low immediately on reset.
    assign bus.bist_done = bus.bist_en & (cnt_q == 6'd63);
    assign bus.bist_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tgate_mux4.sv
`default_nettype none
// ============================================================================
// Module      : tb_tgate_mux4
// Description : Self-checking bench for tgate_mux4 (WIDTH=4) with a
//               behavioural model of selection, registering and the sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tgate_mux4;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tgate_mux4_if #(.WIDTH(WIDTH)) bus ();
    tgate_mux4 #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    logic [WIDTH-1:0] xs [4];
    logic [WIDTH-1:0] m_outq;
    int               m_cnt;

    function automatic logic [WIDTH-1:0] model_comb();
        int idx;
        bit b;
        if (bus.bist_en) begin
            // pattern bit number (cnt / 16) of the counter value
            b = ((m_cnt >> (m_cnt / 16)) & 1) != 0;
            return b ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        end
        idx = 2 * int'(bus.c1) + int'(bus.c0);
        return xs[idx];
    endfunction

    task automatic drive_ports(input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1,
                               input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] a3,
                               input logic s0, input logic s1);
        xs[0] = a0; xs[1] = a1; xs[2] = a2; xs[3] = a3;
        bus.x0 = a0; bus.x1 = a1; bus.x2 = a2; bus.x3 = a3;
        bus.c0 = s0; bus.c1 = s1;
    endtask

    task automatic drive_random();
        drive_ports(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                    WIDTH'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // Advance one clock and update the model at the edge.
    task automatic tick();
        @(posedge clk);
        m_outq = model_comb();
        if (bus.bist_en) m_cnt = (m_cnt + 1) % 64;
        #1;
    endtask

    task automatic reset_dut();
        #2 rst_n = 1'b0;
        m_cnt  = 0;
        m_outq = '0;
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bus.bist_en = 1'b1;
        repeat (5) tick();
        bus.bist_en = 1'b0;
        drive_ports('1, '0, '0, '0, 1'b0, 1'b0);
        tick();
        n_tests++;
        if (bus.out_q !== '1) begin
            n_fail++; $display("FAIL pre_reset_out_q: got %h expected %h", bus.out_q, {WIDTH{1'b1}});
        end
        #2 rst_n = 1'b0;
        bus.bist_en = 1'b1;
        #1;
        n_tests++;
        if (bus.out_q !== '0) begin
            n_fail++; $display("FAIL reset_out_q: got %h expected 0", bus.out_q);
        end
        n_tests++;
        if (bus.bist_done !== 1'b0 || bus.bist_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got done=%b err=%b expected 0 0", bus.bist_done, bus.bist_err);
        end
        n_tests++;
        if (bus.out_comb !== '0) begin
            n_fail++; $display("FAIL reset_cnt_cleared: got out_comb=%h expected 0", bus.out_comb);
        end
        m_cnt = 0; m_outq = '0;
        bus.bist_en = 1'b0;
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_static_select();
        drive_ports('1, '0, '0, '0, 1'b0, 1'b0);
        #1;
        n_tests++;
        if (bus.out_comb !== '1) begin
            n_fail++; $display("FAIL static_comb_00: got %h expected %h", bus.out_comb, {WIDTH{1'b1}});
        end
        tick();
        n_tests++;
        if (bus.out_q !== '1) begin
            n_fail++; $display("FAIL static_q_00: got %h expected %h", bus.out_q, {WIDTH{1'b1}});
        end
        bus.c0 = 1'b1;
        #1;
        n_tests++;
        if (bus.out_comb !== '0) begin
            n_fail++; $display("FAIL static_comb_01: got %h expected 0", bus.out_comb);
        end
        n_tests++;
        if (bus.out_q !== '1) begin
            n_fail++; $display("FAIL static_q_hold: got %h expected %h", bus.out_q, {WIDTH{1'b1}});
        end
        tick();
        n_tests++;
        if (bus.out_q !== '0) begin
            n_fail++; $display("FAIL static_q_01: got %h expected 0", bus.out_q);
        end
    endtask

    task automatic test_walking_ones();
        logic [WIDTH-1:0] v [4];
        logic [WIDTH-1:0] exp;
        for (int sel = 0; sel < 4; sel++) begin
            for (int hot = 0; hot < 4; hot++) begin
                for (int k = 0; k < 4; k++) v[k] = (k == hot) ? '1 : '0;
                drive_ports(v[0], v[1], v[2], v[3], 1'(sel % 2), 1'(sel / 2));
                exp = (hot == sel) ? '1 : '0;
                tick();
                n_tests++;
                if (bus.out_q !== exp) begin
                    n_fail++; $display("FAIL walk sel=%0d hot=%0d: got %h expected %h", sel, hot, bus.out_q, exp);
                end
            end
        end
    endtask

    task automatic test_exhaustive_ports();
        logic [5:0] vv;
        logic [WIDTH-1:0] exp;
        for (int v = 0; v < 64; v++) begin
            vv = 6'(v);
            drive_ports({WIDTH{vv[0]}}, {WIDTH{vv[1]}}, {WIDTH{vv[2]}}, {WIDTH{vv[3]}}, vv[4], vv[5]);
            exp = vv[{vv[5], vv[4]}] ? '1 : '0;
            #1;
            n_tests++;
            if (bus.out_comb !== exp) begin
                n_fail++; $display("FAIL exh_comb v=%0d: got %h expected %h", v, bus.out_comb, exp);
            end
            tick();
            n_tests++;
            if (bus.out_q !== exp) begin
                n_fail++; $display("FAIL exh_q v=%0d: got %h expected %h", v, bus.out_q, exp);
            end
        end
    endtask

    task automatic test_random_ports();
        logic [WIDTH-1:0] exp;
        for (int i = 0; i < 100; i++) begin
            drive_random();
            exp = model_comb();
            #1;
            n_tests++;
            if (bus.out_comb !== exp) begin
                n_fail++; $display("FAIL rand_comb i=%0d: got %h expected %h", i, bus.out_comb, exp);
            end
            tick();
            n_tests++;
            if (bus.out_q !== m_outq) begin
                n_fail++; $display("FAIL rand_q i=%0d: got %h expected %h", i, bus.out_q, m_outq);
            end
        end
    endtask

    // Runs the sweep for n cycles with random (ignored) port data.
    task automatic bist_run(input int n, output int pulses, output int first_idx);
        logic exp_done;
        logic [WIDTH-1:0] exp_comb;
        pulses = 0; first_idx = -1;
        bus.bist_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive_random();
            @(negedge clk);
            exp_done = (m_cnt == 63);
            exp_comb = model_comb();
            n_tests++;
            if (bus.bist_done !== exp_done) begin
                n_fail++; $display("FAIL bist_done cnt=%0d: got %b expected %b", m_cnt, bus.bist_done, exp_done);
            end
            n_tests++;
            if (bus.out_comb !== exp_comb) begin
                n_fail++; $display("FAIL bist_comb cnt=%0d: got %h expected %h", m_cnt, bus.out_comb, exp_comb);
            end
            n_tests++;
            if (bus.out_q !== m_outq || bus.bist_err !== 1'b0) begin
                n_fail++; $display("FAIL bist_q_err cnt=%0d: got q=%h err=%b expected q=%h err=0", m_cnt, bus.out_q, bus.bist_err, m_outq);
            end
            if (bus.bist_done === 1'b1) begin
                pulses++;
                if (first_idx < 0) first_idx = i;
            end
            tick();
        end
    endtask

    task automatic test_bist_sweep();
        int p, f;
        reset_dut();
        bist_run(70, p, f);
        n_tests++;
        if (p != 1 || f != 63) begin
            n_fail++; $display("FAIL sweep_pulse: got pulses=%0d at=%0d expected 1 at 63", p, f);
        end
    endtask

    task automatic test_bist_resume();
        int p, f, exp_f;
        bus.bist_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_random();
            @(negedge clk);
            n_tests++;
            if (bus.bist_done !== 1'b0 || bus.bist_err !== 1'b0 || bus.out_q !== m_outq) begin
                n_fail++; $display("FAIL pause i=%0d: got done=%b err=%b q=%h expected 0 0 %h", i, bus.bist_done, bus.bist_err, bus.out_q, m_outq);
            end
            tick();
        end
        exp_f = 63 - m_cnt;
        bist_run(70, p, f);
        n_tests++;
        if (p != 1 || f != exp_f) begin
            n_fail++; $display("FAIL resume_pulse: got pulses=%0d at=%0d expected 1 at %0d", p, f, exp_f);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int p, f;
        reset_dut();
        bist_run(37, p, f);
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.out_q !== '0 || bus.bist_done !== 1'b0 || bus.bist_err !== 1'b0 || bus.out_comb !== '0) begin
            n_fail++; $display("FAIL midreset_clear: got q=%h done=%b err=%b comb=%h expected all 0", bus.out_q, bus.bist_done, bus.bist_err, bus.out_comb);
        end
        m_cnt = 0; m_outq = '0;
        #1 rst_n = 1'b1;
        bist_run(70, p, f);
        n_tests++;
        if (p != 1 || f != 63) begin
            n_fail++; $display("FAIL midreset_pulse: got pulses=%0d at=%0d expected 1 at 63", p, f);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.bist_en = 1'b0;
        drive_ports('0, '0, '0, '0, 1'b0, 1'b0);
        m_cnt = 0; m_outq = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_static_select();
        test_walking_ones();
        test_exhaustive_ports();
        test_random_ports();
        test_bist_sweep();
        test_bist_resume();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/tgate_mux4.md
Name: tgate_mux4

Overview:
- 4:1 multiplexer modelled on a two-level CMOS transmission-gate tree.
  - Stage 1 pairs X0/X1 and X2/X3 under select C0.
  - Stage 2 picks between the stage-1 results under select C1.
- Provides a combinational output and a registered output.
- Includes a built-in exhaustive pattern sweep with a self-check.
- Sits at the leaf of the datapath as a verified selection primitive.

Parameters:
- WIDTH, 1, data width of each input and of both outputs.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- x0  input  WIDTH  data input, selected when {c1,c0}=00.
- x1  input  WIDTH  data input, selected when {c1,c0}=01.
- x2  input  WIDTH  data input, selected when {c1,c0}=10.
- x3  input  WIDTH  data input, selected when {c1,c0}=11.
- c0  input  1  first-level select.
- c1  input  1  second-level select.
- bist_en  input  1  1 = internal sweep drives the mux; 0 = ports drive it.
- out_comb  output  WIDTH  combinational mux result.
- out_q  output  WIDTH  out_comb registered on clk.
- bist_done  output  1  one-cycle pulse when the sweep counter wraps.
- bist_err  output  1  sticky mismatch flag.

Behaviour:
- Reset is asynchronous and active-low: assertion of rst_n=0 takes effect immediately, independent of clk; one clock, rising edge.
- Effective inputs:
  - bist_en=0: the x0..x3, c0 and c1 ports.
  - bist_en=1: a 6-bit counter cnt drives the mux.
    - x0=cnt[0], x1=cnt[1], x2=cnt[2], x3=cnt[3], each replicated across WIDTH bits.
    - c0=cnt[4], c1=cnt[5].
- Selection structure, evaluated per bit:
  - Stage 1: a = c0 ? x1 : x0; b = c0 ? x3 : x2.
  - Stage 2: out_comb = c1 ? b : a.
  - Net result: out_comb = x[{c1,c0}].
- out_comb is purely combinational. No latch, no X-propagation beyond the selected input.
- out_q takes the value of out_comb on each rising clk edge: latency 1 cycle.
- Counter behaviour:
  - Increments by 1 each clock while bist_en=1.
  - Wraps 63 -> 0.
  - Holds its value while bist_en=0.
  - Is not cleared when bist_en falls; the sweep resumes from the held value.
- bist_done is asserted for the cycle in which cnt transitions 63 -> 0.
- Self-check:
  - expected = cnt[{cnt[5],cnt[4]}] is registered alongside out_q.
  - From the second cycle of bist_en=1 onward, bit 0 of out_q is compared against the registered expected value; the comparison is skipped on the first cycle of bist_en=1.
  - Any mismatch sets bist_err. It stays set until reset.
- When bist_en=0: bist_done=0 and bist_err holds its value.
- Reset values: out_q=0, cnt=0, bist_done=0, bist_err=0, internal expected register=0.
- Reset asserted mid-sweep: all of the above clear immediately. After release the sweep restarts from cnt=0.
- A select change alone (data stable) updates out_comb in the same cycle and out_q on the next edge.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> out_q=0, bist_err=0, bist_done=0 immediately, without waiting for a clk edge.
- Static select:
  - x0=1, x1=0, x2=0, x3=0, {c1,c0}=00 -> out_comb=1; out_q=1 after one edge.
  - Change to {c1,c0}=01 -> out_comb=0.
- Walking ones: for sel = 0..3, set only x[sel]=1 -> out_q=1. Every other sel value gives 0.
- Exhaustive ports:
  - Drive all 64 combinations of {c1,c0,x3,x2,x1,x0} with bist_en=0.
  - Each cycle, out_q equals the previous cycle's x[{c1,c0}].
- BIST sweep:
  - bist_en=1 for 70 cycles after reset -> bist_done pulses exactly once, on the 63 -> 0 cycle; bist_err stays 0.
  - Deassert then reassert bist_en -> the sweep resumes from the held cnt and bist_err stays 0.
- Reset mid-sweep: pulse rst_n low at cnt=37 -> cnt=0 and outputs cleared. After release, bist_done pulses 64 cycles later.
